sobel_scan_ctrl: RTL and testbench
==================================

Name: sobel_scan_ctrl

Overview:
Scan controller that sequences the 3x3 Sobel patch accelerator across a rectangular 8-bit image in SRAM. It walks every valid 3x3 patch position in row-major order and hands each patch base address to the accelerator. It runs the accelerator's level start/done handshake per patch and accumulates a match count and the first matching position. It sits between the MMIO register block (config, go, status) and the accelerator (start, patch address, done, match).

Parameters:
DIM_W, 8, bit width of image width/height and patch coordinates
CNT_W, 16, bit width of the match counter (saturating)
TIMEOUT, 1024, max cycles in WAIT_DONE before a timeout error; 0 disables the watchdog

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
cfg_base  in  32  byte address of pixel (0,0)
cfg_width  in  DIM_W  image width in pixels
cfg_height  in  DIM_W  image height in pixels
cfg_stride  in  16  row pitch in bytes
go  in  1  single-cycle start-scan pulse
abort  in  1  single-cycle abort pulse
busy  out  1  scan in progress
scan_done  out  1  scan finished; held until next accepted go
err_cfg  out  1  width<3 or height<3 at go
err_timeout  out  1  accelerator did not answer within TIMEOUT
aborted  out  1  scan ended by abort
match_count  out  CNT_W  number of patches with accel_match=1, saturating
first_valid  out  1  first_x/first_y hold a match
first_x  out  DIM_W  x of first matching patch (top-left pixel)
first_y  out  DIM_W  y of first matching patch
accel_start  out  1  level start to accelerator
accel_patch_addr  out  32  patch base address to accelerator
accel_done  in  1  accelerator done level
accel_match  in  1  accelerator match, valid while accel_done=1

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. rst mid-scan returns to IDLE at once with accel_start=0. The accelerator self-recovers because start is low.
- States: IDLE, LAUNCH, WAIT_DONE, RELEASE, FINISH.
- IDLE: go=1 samples all cfg_* into shadow registers. It clears match_count, first_valid, scan_done and the err/aborted flags, and sets x=y=0 and row_addr=cfg_base.
  - If width<3 or height<3: set err_cfg and go to FINISH.
  - Otherwise go to LAUNCH. busy=1 from the cycle after go.
- go while busy is ignored. cfg_* changes during a scan have no effect.
- LAUNCH (1 cycle): accel_patch_addr=row_addr+x and accel_start=1, then go to WAIT_DONE.
- WAIT_DONE: hold accel_start=1 and the address stable.
  - On accel_done=1, sample accel_match. If 1: match_count+1, saturating at all-ones. If first_valid=0, latch first_x/first_y and set first_valid. Then go to RELEASE.
  - Watchdog counts cycles in WAIT_DONE. When it reaches TIMEOUT, set err_timeout and go to RELEASE without sampling a match.
- RELEASE: accel_start=0. Wait for accel_done=0 (accelerator back in idle). On a timeout entry, wait at most 1 cycle.
  - Then advance the position: x+1. If x==width-3: x=0, y+1, row_addr+=stride.
  - Go to FINISH if the last patch is done (x==width-3 and y==height-3), or on a pending abort or timeout. Otherwise go to LAUNCH.
- Address arithmetic: 32-bit modulo 2^32, no multiplier; the row address is accumulated.
- abort: pulse latched as abort_pend while busy.
  - The in-flight patch always completes its handshake; its result is counted.
  - Then go to FINISH with aborted=1.
  - abort in IDLE or FINISH is ignored. go and abort in the same IDLE cycle: go wins, abort is ignored.
- FINISH (1 cycle): busy=0, scan_done=1, then IDLE.
- Result outputs hold their values until the next accepted go.
- Total patches = (W-2)*(H-2). Minimum per-patch latency in this controller is 3 cycles plus the accelerator latency.

Decomposition:
- Shared package sobel_pkg: state_t enum (used by the FSM and bench), MIN_DIM=3, default DIM_W/CNT_W constants.
- One natural sub-module: sobel_scan_addr_gen. It holds the x/y counters and row-address accumulator, with step/clear inputs and a last flag.

Test Plan:
- 4x4 image, base 0x1000_0000, stride 4, accel model always match=1 -> 4 patches at addresses 0x1000_0000, +1, +4, +5; match_count=4; first=(0,0); scan_done=1.
- 5x3 image, stride 8, match only on x=2 -> addresses base+0,+1,+2; match_count=1; first_x=2, first_y=0.
- width=2, height=10 -> err_cfg=1, scan_done=1 within 2 cycles, accel_start never asserted.
- Accelerator model never asserts done, TIMEOUT=16 -> err_timeout=1 after 16 WAIT_DONE cycles, accel_start drops, scan_done=1.
- 10x10 image, abort pulsed during the 3rd patch -> exactly 3 handshakes complete, aborted=1, match_count<=3. A go pulse while busy is ignored.
- CNT_W=2, 4x6 image all match -> match_count saturates at 3. cfg_base=0xFFFF_FFFE with x advance wraps accel_patch_addr to 0x0000_0000.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel patch scan controller.
// Imported by the FSM, the address generator and the bench.
package sobel_pkg;

    localparam int MIN_DIM     = 3;
    localparam int DEF_DIM_W   = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RELEASE,
        FINISH
    } state_t;

    // Index of the last valid patch origin along one image dimension.
    function automatic logic [31:0] last_origin(input logic [31:0] dim);
        return dim - 32'(MIN_DIM);
    endfunction

endpackage

// File: rtl/sobel_scan_addr_gen.sv
// Patch position walker: x/y counters plus an accumulated row address.
// Geometry is captured on load so later cfg changes cannot disturb a scan.
module sobel_scan_addr_gen
    import sobel_pkg::*;
#(
    parameter int DIM_W = DEF_DIM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      base,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    input  logic [15:0]      stride,
    output logic [DIM_W-1:0] x,
    output logic [DIM_W-1:0] y,
    output logic [31:0]      patch_addr,
    output logic             last
);

    localparam logic [DIM_W-1:0] EDGE = DIM_W'(MIN_DIM);

    logic [DIM_W-1:0] w_q;
    logic [DIM_W-1:0] h_q;
    logic [15:0]      stride_q;
    logic [31:0]      row_addr;
    logic             row_end;

    assign row_end    = (x == w_q - EDGE);
    assign last       = row_end && (y == h_q - EDGE);
    assign patch_addr = row_addr + 32'(x);

    // Shadow geometry, captured at the start of every scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q      <= '0;
            h_q      <= '0;
            stride_q <= '0;
        end else if (load) begin
            w_q      <= width;
            h_q      <= height;
            stride_q <= stride;
        end
    end

    // Raster walk; row base advances by stride instead of y*stride.
    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            row_addr <= '0;
        end else if (load) begin
            x        <= '0;
            y        <= '0;
            row_addr <= base;
        end else if (step) begin
            if (row_end) begin
                x        <= '0;
                y        <= y + DIM_W'(1);
                row_addr <= row_addr + 32'(stride_q);
            end else begin
                x        <= x + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/sobel_scan_ctrl.sv
// Sequences the 3x3 Sobel accelerator over every patch of an image,
// counting matches and remembering the first matching position.
module sobel_scan_ctrl
    import sobel_pkg::*;
#(
    parameter int DIM_W   = DEF_DIM_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cfg_base,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [15:0]      cfg_stride,
    input  logic             go,
    input  logic             abort,
    output logic             busy,
    output logic             scan_done,
    output logic             err_cfg,
    output logic             err_timeout,
    output logic             aborted,
    output logic [CNT_W-1:0] match_count,
    output logic             first_valid,
    output logic [DIM_W-1:0] first_x,
    output logic [DIM_W-1:0] first_y,
    output logic             accel_start,
    output logic [31:0]      accel_patch_addr,
    input  logic             accel_done,
    input  logic             accel_match
);

    localparam logic [DIM_W-1:0] MIN_D   = DIM_W'(MIN_DIM);
    localparam int               WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic             WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           next_state;
    logic [WD_W-1:0]  wd;
    logic             abort_pend;
    logic             abort_any;
    logic             cfg_bad;
    logic             load;
    logic             take;
    logic             wd_fire;
    logic             rel_exit;
    logic             last;
    logic [DIM_W-1:0] pos_x;
    logic [DIM_W-1:0] pos_y;

    assign cfg_bad   = (cfg_width < MIN_D) || (cfg_height < MIN_D);
    assign load      = (state == IDLE) && go;
    assign take      = (state == WAIT_DONE) && accel_done;
    assign wd_fire   = (state == WAIT_DONE) && !accel_done
                    && WD_EN && (wd == WD_LAST);
    assign rel_exit  = (state == RELEASE) && (!accel_done || err_timeout);
    assign abort_any = abort_pend || abort;

    sobel_scan_addr_gen #(
        .DIM_W (DIM_W)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (rel_exit),
        .base       (cfg_base),
        .width      (cfg_width),
        .height     (cfg_height),
        .stride     (cfg_stride),
        .x          (pos_x),
        .y          (pos_y),
        .patch_addr (accel_patch_addr),
        .last       (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic for the per-patch handshake walk.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (go) next_state = cfg_bad ? FINISH : LAUNCH;
            end
            LAUNCH: begin
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (take || wd_fire) next_state = RELEASE;
            end
            RELEASE: begin
                if (rel_exit) begin
                    if (last || abort_any || err_timeout)
                        next_state = FINISH;
                    else
                        next_state = LAUNCH;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        busy        = 1'b0;
        accel_start = 1'b0;
        unique case (state)
            LAUNCH, WAIT_DONE: begin
                busy        = 1'b1;
                accel_start = 1'b1;
            end
            RELEASE: begin
                busy = 1'b1;
            end
            default: begin
                busy        = 1'b0;
                accel_start = 1'b0;
            end
        endcase
    end

    // Watchdog: cycles spent waiting for the current patch.
    always_ff @(posedge clk) begin
        if (rst)                     wd <= '0;
        else if (state == LAUNCH)    wd <= '0;
        else if (state == WAIT_DONE) wd <= wd + WD_W'(1);
    end

    // Abort is remembered until the in-flight patch has released.
    always_ff @(posedge clk) begin
        if (rst)                          abort_pend <= 1'b0;
        else if (load || state == FINISH) abort_pend <= 1'b0;
        else if (abort && busy)           abort_pend <= 1'b1;
    end

    // Result and status registers, held until the next accepted go.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_count <= '0;
            first_valid <= 1'b0;
            first_x     <= '0;
            first_y     <= '0;
            scan_done   <= 1'b0;
            err_cfg     <= 1'b0;
            err_timeout <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            if (load) begin
                match_count <= '0;
                first_valid <= 1'b0;
                first_x     <= '0;
                first_y     <= '0;
                scan_done   <= 1'b0;
                err_cfg     <= cfg_bad;
                err_timeout <= 1'b0;
                aborted     <= 1'b0;
            end
            if (take && accel_match) begin
                if (match_count != CNT_MAX)
                    match_count <= match_count + CNT_W'(1);
                if (!first_valid) begin
                    first_valid <= 1'b1;
                    first_x     <= pos_x;
                    first_y     <= pos_y;
                end
            end
            if (wd_fire)
                err_timeout <= 1'b1;
            if (rel_exit && abort_any)
                aborted <= 1'b1;
            if (next_state == FINISH && state != FINISH)
                scan_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Bench for sobel_scan_ctrl: randomized accelerator latency and match
// pattern, checked against a raster-order reference of the patch walk.
module tb_sobel_scan_ctrl;
    import sobel_pkg::*;

    localparam int DW = 8;
    localparam int CW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   cfg_base;
    logic [DW-1:0] cfg_width;
    logic [DW-1:0] cfg_height;
    logic [15:0]   cfg_stride;
    logic          go;
    logic          abort;
    logic          busy, scan_done, err_cfg, err_timeout, aborted;
    logic [CW-1:0] match_count;
    logic          first_valid;
    logic [DW-1:0] first_x, first_y;
    logic          accel_start;
    logic [31:0]   accel_patch_addr;
    logic          accel_done = 1'b0;
    logic          accel_match = 1'b0;

    logic          d2_busy, d2_scan_done, d2_err_cfg, d2_err_timeout;
    logic          d2_aborted, d2_first_valid, d2_accel_start;
    logic [1:0]    d2_match_count;
    logic [DW-1:0] d2_first_x, d2_first_y;
    logic [31:0]   d2_accel_patch_addr;

    always #5 clk = ~clk;

    sobel_scan_ctrl #(.DIM_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cfg_base(cfg_base), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .cfg_stride(cfg_stride),
        .go(go), .abort(abort),
        .busy(busy), .scan_done(scan_done), .err_cfg(err_cfg),
        .err_timeout(err_timeout), .aborted(aborted),
        .match_count(match_count), .first_valid(first_valid),
        .first_x(first_x), .first_y(first_y),
        .accel_start(accel_start), .accel_patch_addr(accel_patch_addr),
        .accel_done(accel_done), .accel_match(accel_match)
    );

    sobel_scan_ctrl #(.DIM_W(DW), .CNT_W(2), .TIMEOUT(TO)) dut2 (
        .clk(clk), .rst(rst),
        .cfg_base(cfg_base), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .cfg_stride(cfg_stride),
        .go(go), .abort(abort),
        .busy(d2_busy), .scan_done(d2_scan_done), .err_cfg(d2_err_cfg),
        .err_timeout(d2_err_timeout), .aborted(d2_aborted),
        .match_count(d2_match_count), .first_valid(d2_first_valid),
        .first_x(d2_first_x), .first_y(d2_first_y),
        .accel_start(d2_accel_start), .accel_patch_addr(d2_accel_patch_addr),
        .accel_done(accel_done), .accel_match(accel_match)
    );

    int checks = 0;
    int errors = 0;

    // Reference results
    logic [31:0] exp_q[$];
    bit          match_tbl[logic [31:0]];
    int          ref_cnt;
    bit          ref_fv;
    int          ref_fx, ref_fy;

    // Accelerator model state
    logic [31:0] hs_q[$];
    int          done_cnt;
    int          bad_addr;
    bit          never_done = 1'b0;
    bit          in_req = 1'b0;
    int          lat, rel_cnt;
    logic [31:0] cur_addr;

    // Accelerator model: random latency, match looked up by address.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            accel_done  = 1'b0;
            accel_match = 1'b0;
            in_req      = 1'b0;
        end else if (!accel_start) begin
            in_req = 1'b0;
            if (accel_done) begin
                if (rel_cnt == 0) begin
                    accel_done  = 1'b0;
                    accel_match = 1'b0;
                end else begin
                    rel_cnt--;
                end
            end
        end else if (!in_req) begin
            in_req   = 1'b1;
            cur_addr = accel_patch_addr;
            hs_q.push_back(cur_addr);
            lat = int'($urandom_range(0, 3));
        end else begin
            if (accel_patch_addr !== cur_addr) bad_addr++;
            if (!accel_done && !never_done) begin
                if (lat == 0) begin
                    accel_done  = 1'b1;
                    accel_match = match_tbl.exists(cur_addr)
                                ? match_tbl[cur_addr] : 1'b0;
                    rel_cnt = int'($urandom_range(0, 2));
                    done_cnt++;
                end else begin
                    lat--;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    // Build expected walk; mode 0 random, 1 all match, 2 match at x==2.
    task automatic prep(input logic [31:0] base, input int w, input int h,
                        input int stride, input int mode, input int limit);
        logic [31:0] a;
        bit m;
        int n;
        exp_q.delete();
        match_tbl.delete();
        ref_cnt = 0; ref_fv = 0; ref_fx = 0; ref_fy = 0; n = 0;
        for (int yy = 0; yy <= h - 3; yy++) begin
            for (int xx = 0; xx <= w - 3; xx++) begin
                a = base + 32'(yy * stride) + 32'(xx);
                m = (mode == 1) ? 1'b1 :
                    (mode == 2) ? (xx == 2) : 1'($urandom_range(0, 1));
                match_tbl[a] = m;
                if (n < limit) begin
                    exp_q.push_back(a);
                    if (m) begin
                        ref_cnt++;
                        if (!ref_fv) begin
                            ref_fv = 1; ref_fx = xx; ref_fy = yy;
                        end
                    end
                end
                n++;
            end
        end
        cfg_base   = base;
        cfg_width  = DW'(w);
        cfg_height = DW'(h);
        cfg_stride = 16'(stride);
        hs_q.delete();
        done_cnt = 0;
        bad_addr = 0;
    endtask

    task automatic pulse_go();
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic run_scan(input int budget, output int cyc, output int stc,
                            output bit to, output logic b0);
        pulse_go();
        b0 = busy;
        cyc = 0; stc = 0; to = 1'b1;
        while (cyc < budget) begin
            if (scan_done === 1'b1) begin
                to = 1'b0;
                break;
            end
            if (accel_start === 1'b1) stc++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; abort = 1'b0;
        cfg_base = '0; cfg_width = '0; cfg_height = '0; cfg_stride = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, scan_done, err_cfg, err_timeout, aborted,
             first_valid, accel_start} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000000",
                     {busy, scan_done, err_cfg, err_timeout, aborted,
                      first_valid, accel_start});
        end
        checks++;
        if (match_count !== '0 || first_x !== '0 || first_y !== '0) begin
            errors++;
            $display("FAIL reset_results got cnt=%0d x=%0d y=%0d want 0",
                     match_count, first_x, first_y);
        end
        checks++;
        if (accel_patch_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr got %h want 0", accel_patch_addr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dut.state !== IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got state=%0d busy=%b want IDLE/0",
                     dut.state, busy);
        end
    endtask

    task automatic test_basic_4x4();
        int cyc, stc; bit to; logic b0;
        prep(32'h1000_0000, 4, 4, 4, 1, 1000);
        run_scan(2000, cyc, stc, to, b0);
        checks++;
        if (to || b0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_run got timeout=%0b busy0=%b want 0/1", to, b0);
        end
        checks++;
        if (hs_q.size() != 4) begin
            errors++;
            $display("FAIL basic_npatch got %0d want 4", hs_q.size());
        end
        for (int i = 0; i < hs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (hs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_addr[%0d] got %h want %h",
                         i, hs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (match_count !== 16'd4 || first_valid !== 1'b1 ||
            first_x !== 8'd0 || first_y !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got cnt=%0d fv=%b x=%0d y=%0d busy=%b want 4/1/0/0/0",
                     match_count, first_valid, first_x, first_y, busy);
        end
    endtask

    task automatic test_match_x2();
        int cyc, stc; bit to; logic b0;
        prep(32'h2000_0000, 5, 3, 8, 2, 1000);
        run_scan(2000, cyc, stc, to, b0);
        checks++;
        if (to || hs_q.size() != 3) begin
            errors++;
            $display("FAIL x2_run got timeout=%0b n=%0d want 0/3", to, hs_q.size());
        end
        for (int i = 0; i < hs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (hs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL x2_addr[%0d] got %h want %h", i, hs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (match_count !== 16'd1 || first_valid !== 1'b1 ||
            first_x !== 8'd2 || first_y !== 8'd0) begin
            errors++;
            $display("FAIL x2_result got cnt=%0d fv=%b x=%0d y=%0d want 1/1/2/0",
                     match_count, first_valid, first_x, first_y);
        end
    endtask

    task automatic test_cfg_err();
        int cyc, stc; bit to; logic b0;
        prep(32'h3000_0000, 2, 10, 16, 1, 1000);
        run_scan(20, cyc, stc, to, b0);
        checks++;
        if (to || cyc > 1) begin
            errors++;
            $display("FAIL cfg_err_latency got timeout=%0b cycles=%0d want 0/<=1",
                     to, cyc);
        end
        checks++;
        if (err_cfg !== 1'b1 || scan_done !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_flags got err_cfg=%b done=%b to=%b want 1/1/0",
                     err_cfg, scan_done, err_timeout);
        end
        checks++;
        if (stc != 0 || hs_q.size() != 0) begin
            errors++;
            $display("FAIL cfg_err_start got start_cycles=%0d hs=%0d want 0/0",
                     stc, hs_q.size());
        end
    endtask

    task automatic test_timeout();
        int cyc, stc; bit to; logic b0;
        never_done = 1'b1;
        prep(32'h4000_0000, 4, 4, 4, 1, 1000);
        run_scan(500, cyc, stc, to, b0);
        never_done = 1'b0;
        checks++;
        if (to || err_timeout !== 1'b1 || scan_done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flags got run_to=%0b err_to=%b done=%b want 0/1/1",
                     to, err_timeout, scan_done);
        end
        checks++;
        if (stc != TO + 1) begin
            errors++;
            $display("FAIL timeout_start_cycles got %0d want %0d", stc, TO + 1);
        end
        checks++;
        if (hs_q.size() != 1 || done_cnt != 0 || accel_start !== 1'b0 ||
            match_count !== '0) begin
            errors++;
            $display("FAIL timeout_state got hs=%0d done=%0d start=%b cnt=%0d want 1/0/0/0",
                     hs_q.size(), done_cnt, accel_start, match_count);
        end
    endtask

    task automatic test_abort_and_go_busy();
        int cyc; bit to, gsent, asent;
        prep($urandom, 10, 10, 16, 0, 3);
        pulse_go();
        gsent = 0; asent = 0; cyc = 0; to = 1;
        while (cyc < 3000) begin
            go = 1'b0; abort = 1'b0;
            if (scan_done === 1'b1) begin
                to = 0;
                break;
            end
            if (!gsent && hs_q.size() == 2) begin
                go = 1'b1; cfg_width = 8'd3; gsent = 1;
            end else if (!asent && hs_q.size() == 3) begin
                abort = 1'b1; asent = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        go = 1'b0; abort = 1'b0;
        checks++;
        if (to || hs_q.size() != 3 || done_cnt != 3) begin
            errors++;
            $display("FAIL abort_handshakes got to=%0b hs=%0d done=%0d want 0/3/3",
                     to, hs_q.size(), done_cnt);
        end
        for (int i = 0; i < hs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (hs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_addr[%0d] got %h want %h", i, hs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (aborted !== 1'b1 || busy !== 1'b0 || err_cfg !== 1'b0 ||
            match_count !== 16'(ref_cnt)) begin
            errors++;
            $display("FAIL abort_result got ab=%b busy=%b ecfg=%b cnt=%0d want 1/0/0/%0d",
                     aborted, busy, err_cfg, match_count, ref_cnt);
        end
    endtask

    task automatic test_saturate();
        int cyc, stc; bit to; logic b0;
        prep(32'h5000_0100, 4, 6, 32, 1, 1000);
        run_scan(3000, cyc, stc, to, b0);
        checks++;
        if (to || match_count !== 16'd8 || d2_match_count !== 2'd3) begin
            errors++;
            $display("FAIL saturate got to=%0b cnt=%0d cnt2=%0d want 0/8/3",
                     to, match_count, d2_match_count);
        end
    endtask

    task automatic test_wrap();
        int cyc, stc; bit to; logic b0;
        prep(32'hFFFF_FFFE, 5, 3, 16, 0, 1000);
        run_scan(2000, cyc, stc, to, b0);
        checks++;
        if (to || hs_q.size() != 3) begin
            errors++;
            $display("FAIL wrap_run got to=%0b n=%0d want 0/3", to, hs_q.size());
        end else begin
            checks++;
            if (hs_q[2] !== 32'h0 || hs_q[0] !== 32'hFFFF_FFFE) begin
                errors++;
                $display("FAIL wrap_addr got %h,%h want fffffffe,00000000",
                         hs_q[0], hs_q[2]);
            end
        end
        checks++;
        if (match_count !== 16'(ref_cnt)) begin
            errors++;
            $display("FAIL wrap_count got %0d want %0d", match_count, ref_cnt);
        end
    endtask

    task automatic test_random();
        int cyc, stc, w, h; bit to; logic b0;
        for (int it = 0; it < 6; it++) begin
            w = int'($urandom_range(3, 7));
            h = int'($urandom_range(3, 6));
            prep($urandom, w, h, int'($urandom_range(w, 64)), 0, 1000);
            run_scan(4000, cyc, stc, to, b0);
            checks++;
            if (to || hs_q.size() != exp_q.size() ||
                done_cnt != exp_q.size() || bad_addr != 0) begin
                errors++;
                $display("FAIL rand%0d_walk got to=%0b hs=%0d done=%0d bad=%0d want 0/%0d/%0d/0",
                         it, to, hs_q.size(), done_cnt, bad_addr,
                         exp_q.size(), exp_q.size());
            end
            for (int i = 0; i < hs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (hs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_addr[%0d] got %h want %h",
                             it, i, hs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (match_count !== 16'(ref_cnt) || first_valid !== ref_fv ||
                (ref_fv && (first_x !== DW'(ref_fx) || first_y !== DW'(ref_fy)))) begin
                errors++;
                $display("FAIL rand%0d_result got cnt=%0d fv=%b x=%0d y=%0d want %0d/%0b/%0d/%0d",
                         it, match_count, first_valid, first_x, first_y,
                         ref_cnt, ref_fv, ref_fx, ref_fy);
            end
            checks++;
            if ({err_cfg, err_timeout, aborted, busy} !== 4'b0) begin
                errors++;
                $display("FAIL rand%0d_flags got %b want 0000", it,
                         {err_cfg, err_timeout, aborted, busy});
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        prep(32'h6000_0000, 6, 6, 8, 1, 1000);
        pulse_go();
        cyc = 0;
        while (hs_q.size() < 2 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cyc >= 500 || accel_start !== 1'b0 || busy !== 1'b0 ||
            dut.state !== IDLE || match_count !== '0) begin
            errors++;
            $display("FAIL mid_reset got wait=%0d start=%b busy=%b state=%0d cnt=%0d want <500/0/0/IDLE/0",
                     cyc, accel_start, busy, dut.state, match_count);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_4x4();
        test_match_x2();
        test_cfg_err();
        test_timeout();
        test_abort_and_go_busy();
        test_saturate();
        test_wrap();
        test_random();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
